// File: rtl/pcc_frame_loader_if.sv
// Stream bundle between the feature source, the frame loader and the pcc classifier.
//   s_valid/s_ready/s_data/s_last : one quantised feature per transfer, s_last ends a frame
//   m_valid/m_ready/pos_out/neg_out : completed binarised frame toward pcc
// slave  : loader view (consumes features, produces frames)
// master : environment view (produces features, consumes frames)
interface pcc_frame_loader_if #(
   parameter int unsigned N_POS = 1,
   parameter int unsigned N_NEG = 2,
   parameter int unsigned FW    = 8
);

   logic             s_valid;
   logic             s_ready;
   logic [FW-1:0]    s_data;
   logic             s_last;
   logic             m_valid;
   logic             m_ready;
   logic [N_POS-1:0] pos_out;
   logic [N_NEG-1:0] neg_out;

   modport slave (
      input  s_valid, s_data, s_last, m_ready,
      output s_ready, m_valid, pos_out, neg_out
   );

   modport master (
      output s_valid, s_data, s_last, m_ready,
      input  s_ready, m_valid, pos_out, neg_out
   );

endinterface

// File: rtl/pcc_frame_loader.sv
// Frame loader feeding the popcount-compare classifier.
// Binarises one feature per transfer against its threshold (feature >= threshold) and packs
// the bits into pos/neg vectors, then holds the frame until pcc accepts it.
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   thr  : per-feature thresholds, feature k uses thr[k*FW +: FW]; static during a frame
//   bus  : feature input stream and frame output stream (slave modport)
//   err  : sticky frame-length error, cleared only by rst
module pcc_frame_loader #(
   parameter int unsigned N_POS = 1,
   parameter int unsigned N_NEG = 2,
   parameter int unsigned FW    = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [(N_POS+N_NEG)*FW-1:0]  thr,
   pcc_frame_loader_if.slave            bus,
   output logic                         err
);

   localparam int unsigned N  = N_POS + N_NEG;
   localparam int unsigned CW = ($clog2(N + 1) < 1) ? 1 : $clog2(N + 1);

   typedef enum logic [0:0] {StCollect, StFull} state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [N-1:0]    bits_q, bits_d;
   logic            err_q, err_d;

   logic [FW-1:0]   thr_sel;
   logic            bit_in;
   logic            in_ready;
   logic            out_valid;
   logic            xfer;
   logic            last_slot;

   // Threshold for the feature slot currently being filled.
   always_comb begin
      thr_sel = '0;
      for (int k = 0; k < N; k++) begin
         if (cnt_q == CW'(k)) thr_sel = thr[k*FW +: FW];
      end
      bit_in = (bus.s_data >= thr_sel);
   end

   assign xfer      = bus.s_valid & in_ready;
   assign last_slot = (cnt_q == CW'(N - 1));

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= StCollect;
      else     state_q <= state_d;
   end

   // Next state: a frame ends on the N-th feature or on an early s_last.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StCollect: if (xfer && (last_slot || bus.s_last)) state_d = StFull;
         StFull:    if (bus.m_ready) state_d = StCollect;
         default:   state_d = StCollect;
      endcase
   end

   // Outputs.
   always_comb begin
      in_ready    = (state_q == StCollect);
      out_valid   = (state_q == StFull);
      bus.s_ready = in_ready;
      bus.m_valid = out_valid;
      bus.pos_out = bits_q[N_POS-1:0];
      bus.neg_out = bits_q[N-1:N_POS];
      err         = err_q;
   end

   // Datapath next state: bit packing, feature counter, sticky error.
   always_comb begin
      bits_d = bits_q;
      cnt_d  = cnt_q;
      err_d  = err_q;
      if (state_q == StCollect) begin
         if (xfer) begin
            for (int k = 0; k < N; k++) begin
               if (cnt_q == CW'(k)) begin
                  bits_d[k] = bit_in;
               end else if ((CW'(k) > cnt_q) && bus.s_last) begin
                  // Short frame: slots never received read as 0.
                  bits_d[k] = 1'b0;
               end
            end
            if (last_slot || bus.s_last) cnt_d = '0;
            else                         cnt_d = cnt_q + 1'b1;
            // Length error when s_last disagrees with the N-th slot.
            if (last_slot != bus.s_last) err_d = 1'b1;
         end
      end else if (bus.m_ready) begin
         bits_d = '0;
         cnt_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q  <= '0;
         bits_q <= '0;
         err_q  <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         bits_q <= bits_d;
         err_q  <= err_d;
      end
   end

endmodule

// File: tb/tb_pcc_frame_loader.sv
// Directed bench for pcc_frame_loader (N_POS=1, N_NEG=2, FW=8).
// Inputs are driven and outputs sampled on the falling edge.
module tb_pcc_frame_loader;

   logic        clk;
   logic        rst;
   logic [23:0] thr;
   logic        err;

   int total;
   int bad;

   pcc_frame_loader_if #(.N_POS(1), .N_NEG(2), .FW(8)) bus ();

   pcc_frame_loader #(.N_POS(1), .N_NEG(2), .FW(8)) dut (
      .clk (clk),
      .rst (rst),
      .thr (thr),
      .bus (bus),
      .err (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One transfer: the loader is in collect, so the word is taken at the next rising edge.
   task automatic send(input logic [7:0] d, input logic l);
      bus.s_valid = 1'b1;
      bus.s_data  = d;
      bus.s_last  = l;
      @(negedge clk);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = 8'd0;
   endtask

   task automatic check_frame(input string tag, input logic [0:0] p, input logic [1:0] n,
                              input logic e);
      check_eq({tag, "_mvalid"}, {31'd0, bus.m_valid}, 32'd1);
      check_eq({tag, "_sready"}, {31'd0, bus.s_ready}, 32'd0);
      check_eq({tag, "_pos"},    {31'd0, bus.pos_out}, {31'd0, p});
      check_eq({tag, "_neg"},    {30'd0, bus.neg_out}, {30'd0, n});
      check_eq({tag, "_err"},    {31'd0, err},         {31'd0, e});
   endtask

   task automatic check_idle(input string tag, input logic e);
      check_eq({tag, "_mvalid"}, {31'd0, bus.m_valid}, 32'd0);
      check_eq({tag, "_sready"}, {31'd0, bus.s_ready}, 32'd1);
      check_eq({tag, "_pos"},    {31'd0, bus.pos_out}, 32'd0);
      check_eq({tag, "_neg"},    {30'd0, bus.neg_out}, 32'd0);
      check_eq({tag, "_err"},    {31'd0, err},         {31'd0, e});
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      total       = 0;
      bad         = 0;
      thr         = {8'd50, 8'd30, 8'd100};
      rst         = 1'b1;
      bus.s_valid = 1'b0;
      bus.s_data  = 8'd0;
      bus.s_last  = 1'b0;
      bus.m_ready = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check_idle("reset", 1'b0);

      // Basic frame: 120>=100, 10<30, 50>=50.
      bus.m_ready = 1'b1;
      send(8'd120, 1'b0);
      check_eq("basic_mid1", {31'd0, bus.m_valid}, 32'd0);
      send(8'd10, 1'b0);
      check_eq("basic_mid2", {31'd0, bus.m_valid}, 32'd0);
      send(8'd50, 1'b1);
      check_frame("basic", 1'b1, 2'b10, 1'b0);
      @(negedge clk);
      check_idle("basic_after", 1'b0);

      // Equality boundary and one-below.
      send(8'd100, 1'b0);
      send(8'd30, 1'b0);
      send(8'd50, 1'b1);
      check_frame("eq", 1'b1, 2'b11, 1'b0);
      @(negedge clk);
      send(8'd99, 1'b0);
      send(8'd29, 1'b0);
      send(8'd49, 1'b1);
      check_frame("below", 1'b0, 2'b00, 1'b0);
      @(negedge clk);
      check_idle("below_after", 1'b0);

      // Back-pressure, with s_valid and junk data asserted while full.
      bus.m_ready = 1'b0;
      send(8'd120, 1'b0);
      send(8'd10, 1'b0);
      send(8'd50, 1'b1);
      for (int i = 0; i < 10; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'd255;
         bus.s_last  = 1'b1;
         check_frame("bp_hold", 1'b1, 2'b10, 1'b0);
         @(negedge clk);
      end
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      bus.s_data  = 8'd0;
      check_frame("bp_last", 1'b1, 2'b10, 1'b0);
      bus.m_ready = 1'b1;
      @(negedge clk);
      check_idle("bp_accept", 1'b0);

      // Short frame: a single word with s_last.
      send(8'd120, 1'b1);
      check_frame("short", 1'b1, 2'b00, 1'b1);
      @(negedge clk);
      check_idle("short_after", 1'b1);
      send(8'd120, 1'b0);
      send(8'd10, 1'b0);
      send(8'd50, 1'b1);
      check_frame("post_short", 1'b1, 2'b10, 1'b1);
      @(negedge clk);

      // Missing s_last, then reset while the frame is still held.
      pulse_rst();
      check_idle("rst_clr", 1'b0);
      bus.m_ready = 1'b0;
      send(8'd120, 1'b0);
      send(8'd10, 1'b0);
      send(8'd50, 1'b0);
      check_frame("nolast", 1'b1, 2'b10, 1'b1);
      pulse_rst();
      check_idle("nolast_rst", 1'b0);

      // Reset mid-frame: only the new words may land in the frame.
      bus.m_ready = 1'b1;
      send(8'd120, 1'b0);
      send(8'd10, 1'b0);
      pulse_rst();
      check_idle("midrst", 1'b0);
      send(8'd99, 1'b0);
      check_eq("fresh_mid1", {31'd0, bus.m_valid}, 32'd0);
      send(8'd40, 1'b0);
      check_eq("fresh_mid2", {31'd0, bus.m_valid}, 32'd0);
      send(8'd10, 1'b1);
      check_frame("fresh", 1'b0, 2'b01, 1'b0);
      @(negedge clk);
      check_idle("fresh_after", 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
